pwm_pattern_sequencer: RTL
==========================

PWM_PATTERN_SEQUENCER -- requirements
Module: pwm_pattern_sequencer

Interface
REQ-001 Parameter CNT_W, default 6: PWM counter width; PWM period is 2^CNT_W clocks.
REQ-002 Parameter SEG_N, default 4: number of pattern segments in the table (power of two).
REQ-003 Parameter DWELL_W, default 8: width of the per-segment dwell count, in PWM periods.
REQ-004 sysclk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  level-sampled; in IDLE begins a sequence at segment 0.
REQ-007 stop  in  1  aborts a running sequence.
REQ-008 loop_en  in  1  1 = wrap to segment 0 after the last segment; 0 = one-shot.
REQ-009 enable  in  1  output gate; pulse forced 0 when low, sequencing continues.
REQ-010 cfg_we  in  1  table write strobe.
REQ-011 cfg_addr  in  log2(SEG_N)  table index written.
REQ-012 cfg_duty  in  CNT_W  segment duty, in high clocks per period.
REQ-013 cfg_dwell  in  DWELL_W  segment length in periods.
REQ-014 pulse  out  1  PWM output.
REQ-015 busy  out  1  high in RUN.
REQ-016 seg_idx  out  log2(SEG_N)  current segment.
REQ-017 done  out  1  one-cycle pulse at natural end of a one-shot sequence.

Function
REQ-018 FSM: IDLE, RUN; IDLE->RUN on start; RUN->IDLE on stop or end of last segment with loop_en=0; RUN->RUN on last segment with loop_en=1.
REQ-019 On IDLE->RUN: count=0, seg_idx=0, period counter=0, duty_cur=table[0].duty latched same edge.
REQ-020 In RUN, count increments every clock, wraps 2^CNT_W-1 -> 0; count held at 0 in IDLE.
REQ-021 pulse = busy & enable & (count < duty_cur), combinational from registers; duty 0 = always low, duty 2^CNT_W-1 = high all but one clock.
REQ-022 Period boundary = clock where count is all ones; period counter increments there.
REQ-023 Effective dwell = max(dwell,1); on the boundary ending the final dwell period, seg_idx advances and duty_cur/dwell reload from the new entry on that same edge.
REQ-024 After segment SEG_N-1: loop_en=1 -> seg_idx=0, stay RUN; loop_en=0 -> IDLE, done=1 for exactly the following cycle.
REQ-025 stop in RUN -> IDLE next edge, pulse low from that edge, done not asserted; stop and start together: stop wins.
REQ-026 start while RUN ignored; start held high in IDLE after done restarts next cycle.
REQ-027 cfg_we writes table[cfg_addr] every cycle regardless of state; a write to the active segment takes effect only at its next load.

Reset
REQ-028 rst, synchronous, overrides all inputs: state IDLE, count 0, seg_idx 0, period counter 0, duty_cur 0, all table entries 0, pulse/busy/done 0.
REQ-029 rst asserted mid-RUN aborts with no done pulse; table contents lost.

Configuration
REQ-030 Macro PWM_SEQ_LOOP_EN: defined -> loop_en port present, behaviour per REQ-024; undefined -> loop_en port absent, every sequence one-shot.

Structure
REQ-031 Package pwm_seq_pkg holds CNT_W, SEG_N, DWELL_W defaults and the state enum (IDLE, RUN).
REQ-032 Sub-module pwm_slice: counter plus compare/gate producing pulse and the period-boundary strobe; the sequencer owns table, FSM and dwell logic.

Verification
REQ-033 Table {seg0: duty 16, dwell 2}, start, loop_en=0 -> pulse high 16 of 64 clocks for 128 clocks, then segment advances.
REQ-034 Table {32/1, 0/1, 63/1, 8/3}, one-shot -> seg_idx 0,1,2,3; segment 1 pulse all low; done one cycle at clock 6*64 after start; busy low after.
REQ-035 Same table, loop_en=1 -> seg_idx returns to 0 after 384 clocks, done never asserted.
REQ-036 stop at count=10 of segment 1 -> busy and pulse low next edge, done stays 0; start+stop same cycle from IDLE -> stays IDLE.
REQ-037 Write seg0 duty 40 during seg0 run -> unchanged until seg0 reloads on loop wrap, then 40 high clocks.
REQ-038 enable=0 for one full period mid-segment -> pulse 0, seg_idx timing identical to enable=1 run.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared defaults and FSM state type for the PWM pattern sequencer.
package pwm_seq_pkg;

  localparam int unsigned DefCntW   = 6;
  localparam int unsigned DefSegN   = 4;
  localparam int unsigned DefDwellW = 8;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/pwm_slice.sv
// PWM counter with duty compare and output gating; flags the last clock of each period.
module pwm_slice
  import pwm_seq_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             cnt_en,
  input  logic             busy,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty,
  output logic             pulse,
  output logic             period_end
);

  logic [CNT_W-1:0] count_q, count_d;

  // Counter runs only while the sequencer stays in RUN; any entry or exit restarts it at zero.
  always_comb begin
    count_d = '0;
    if (cnt_en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign pulse      = busy & enable & (count_q < duty);
  assign period_end = busy & (&count_q);

endmodule

// File: rtl/pwm_pattern_sequencer.sv
// PWM pattern sequencer: steps a duty/dwell table through a PWM slice.
// Optional wrap-around is compiled in with PWM_SEQ_LOOP_EN (adds the loop_en port).
module pwm_pattern_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned SEG_N   = DefSegN,
  parameter int unsigned DWELL_W = DefDwellW
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
`ifdef PWM_SEQ_LOOP_EN
  input  logic                     loop_en,
`endif
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [$clog2(SEG_N)-1:0] cfg_addr,
  input  logic [CNT_W-1:0]         cfg_duty,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  output logic                     pulse,
  output logic                     busy,
  output logic [$clog2(SEG_N)-1:0] seg_idx,
  output logic                     done
);

  localparam int unsigned AddrW = $clog2(SEG_N);

  state_e state_q, state_d;

  logic [CNT_W-1:0]   duty_tbl  [SEG_N];
  logic [DWELL_W-1:0] dwell_tbl [SEG_N];

  logic [AddrW-1:0]   seg_q, seg_d;
  logic [DWELL_W-1:0] per_q, per_d;
  logic [DWELL_W-1:0] dwell_cur_q, dwell_cur_d;
  logic [CNT_W-1:0]   duty_cur_q, duty_cur_d;
  logic               done_q, done_d;

  logic               loop;
  logic               period_end;
  logic               seg_end;
  logic               last_seg;
  logic               load;
  logic [DWELL_W-1:0] dwell_eff;

`ifdef PWM_SEQ_LOOP_EN
  assign loop = loop_en;
`else
  assign loop = 1'b0;
`endif

  // A zero dwell still plays its segment for one period.
  assign dwell_eff = (dwell_cur_q == '0) ? DWELL_W'(1) : dwell_cur_q;
  assign seg_end   = period_end && (per_q == dwell_eff - DWELL_W'(1));
  assign last_seg  = (seg_q == AddrW'(SEG_N - 1));

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop || (seg_end && last_seg && !loop)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StRun);
    done_d = (state_q == StRun) && !stop && seg_end && last_seg && !loop;
  end

  // Segment bookkeeping; duty/dwell are snapshotted from the table whenever a segment begins.
  always_comb begin
    seg_d       = seg_q;
    per_d       = per_q;
    duty_cur_d  = duty_cur_q;
    dwell_cur_d = dwell_cur_q;
    load        = 1'b0;
    if (state_q == StIdle) begin
      if (state_d == StRun) begin
        seg_d = '0;
        per_d = '0;
        load  = 1'b1;
      end
    end else if (state_d == StIdle) begin
      seg_d = '0;
      per_d = '0;
    end else if (period_end) begin
      if (seg_end) begin
        per_d = '0;
        seg_d = last_seg ? '0 : seg_q + AddrW'(1);
        load  = 1'b1;
      end else begin
        per_d = per_q + DWELL_W'(1);
      end
    end
    if (load) begin
      duty_cur_d  = duty_tbl[seg_d];
      dwell_cur_d = dwell_tbl[seg_d];
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      seg_q       <= '0;
      per_q       <= '0;
      duty_cur_q  <= '0;
      dwell_cur_q <= '0;
      done_q      <= 1'b0;
      for (int unsigned i = 0; i < SEG_N; i++) begin
        duty_tbl[i]  <= '0;
        dwell_tbl[i] <= '0;
      end
    end else begin
      seg_q       <= seg_d;
      per_q       <= per_d;
      duty_cur_q  <= duty_cur_d;
      dwell_cur_q <= dwell_cur_d;
      done_q      <= done_d;
      if (cfg_we) begin
        duty_tbl[cfg_addr]  <= cfg_duty;
        dwell_tbl[cfg_addr] <= cfg_dwell;
      end
    end
  end

  pwm_slice #(
    .CNT_W (CNT_W)
  ) u_slice (
    .sysclk     (sysclk),
    .rst        (rst),
    .cnt_en     ((state_q == StRun) && (state_d == StRun)),
    .busy       (busy),
    .enable     (enable),
    .duty       (duty_cur_q),
    .pulse      (pulse),
    .period_end (period_end)
  );

  assign seg_idx = seg_q;
  assign done    = done_q;

endmodule
